// File: rtl/chroma_key_mixer.sv
// rtl/chroma_key_mixer.sv - chroma-key compositor of frame-aligned foreground/background pixel streams
// Optional macro CHROMA_KEY_MIXER_KEYED_COUNT_EN: per-frame keyed-pixel counter in register 3.
module chroma_key_mixer #(
    parameter int COLOR_BITS = 8,
    parameter int NUM_KEYS   = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [3*COLOR_BITS-1:0] fg_data,
    input  logic                    fg_valid,
    input  logic                    fg_sop,
    input  logic                    fg_eop,
    output logic                    fg_ready,
    input  logic [3*COLOR_BITS-1:0] bg_data,
    input  logic                    bg_valid,
    input  logic                    bg_sop,
    input  logic                    bg_eop,
    output logic                    bg_ready,
    output logic [3*COLOR_BITS-1:0] out_data,
    output logic                    out_valid,
    output logic                    out_sop,
    output logic                    out_eop,
    input  logic                    out_ready,
    input  logic [3:0]              avs_address,
    input  logic                    avs_write,
    input  logic                    avs_read,
    input  logic [31:0]             avs_writedata,
    output logic [31:0]             avs_readdata
);
    localparam int PW = 3 * COLOR_BITS;
    localparam int DW = COLOR_BITS + 1;
    localparam logic [0:0] ST_ALIGN  = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          aligned_q, aligned_d;
    logic          desync_q, desync_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          sh_en_q, sh_en_d;
    logic          sh_inv_q, sh_inv_d;
    logic [31:0]   frames_q, frames_d;
    logic [PW-1:0] key_q [NUM_KEYS];
    logic [PW-1:0] tol_q [NUM_KEYS];

    logic adv, accept, pair_bad, pair_ok, out_fire, both_sop;
    logic wr_ctrl, wr_status, wr_frames;
    logic en_eff, inv_eff;

    logic          s1_valid_q, s1_sop_q, s1_eop_q, s1_en_q, s1_inv_q;
    logic [PW-1:0] s1_fg_q, s1_bg_q;
    logic [DW-1:0] s1_diff_q [NUM_KEYS][3];
    logic [DW-1:0] diff_d [NUM_KEYS][3];

    logic          match_any, key_hit, sel_bg;
    logic [PW-1:0] s2_data_d;
    logic          s2_valid_q, s2_sop_q, s2_eop_q;
    logic [PW-1:0] s2_data_q;

    logic [31:0]   rd_d;
    logic [31:0]   keyed_rd;
    logic          unused_wdata;

    // Magnitude of a - b; the extra bit of the subtraction is the borrow.
    function automatic logic [DW-1:0] abs_diff(input logic [COLOR_BITS-1:0] a,
                                               input logic [COLOR_BITS-1:0] b);
        logic [DW-1:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[DW-1]) d = {1'b0, b} - {1'b0, a};
        return d;
    endfunction

    assign adv       = !s2_valid_q || out_ready;
    assign both_sop  = fg_valid && fg_sop && bg_valid && bg_sop;
    assign accept    = (state_q == ST_STREAM) && fg_valid && bg_valid && adv;
    assign pair_bad  = accept && ((fg_sop != bg_sop) || (fg_eop != bg_eop));
    assign pair_ok   = accept && !pair_bad;
    assign out_fire  = s2_valid_q && out_ready;
    assign wr_ctrl   = avs_write && (avs_address == 4'd0);
    assign wr_status = avs_write && (avs_address == 4'd1);
    assign wr_frames = avs_write && (avs_address == 4'd2);

    // The SOP pixel of a frame already uses the freshly shadowed CTRL bits.
    assign en_eff  = fg_sop ? ctrl_q[0] : sh_en_q;
    assign inv_eff = fg_sop ? ctrl_q[1] : sh_inv_q;

    always_comb begin
        fg_ready = 1'b0;
        bg_ready = 1'b0;
        if (state_q == ST_ALIGN) begin
            fg_ready = fg_valid && !fg_sop;
            bg_ready = bg_valid && !bg_sop;
        end else begin
            fg_ready = adv && fg_valid && bg_valid;
            bg_ready = adv && fg_valid && bg_valid;
        end
    end

    always_comb begin
        state_d   = state_q;
        aligned_d = aligned_q;
        desync_d  = desync_q;
        ctrl_d    = ctrl_q;
        sh_en_d   = sh_en_q;
        sh_inv_d  = sh_inv_q;
        frames_d  = frames_q;
        if (state_q == ST_ALIGN) begin
            if (both_sop) begin
                state_d   = ST_STREAM;
                aligned_d = 1'b1;
            end
        end else if (pair_bad) begin
            state_d   = ST_ALIGN;
            aligned_d = 1'b0;
        end
        if (pair_ok && fg_sop) begin
            sh_en_d  = ctrl_q[0];
            sh_inv_d = ctrl_q[1];
        end
        if (wr_ctrl) ctrl_d = avs_writedata[1:0];
        if (wr_status && avs_writedata[1]) desync_d = 1'b0;
        if (pair_bad) desync_d = 1'b1;
        if (out_fire && s2_eop_q) frames_d = frames_q + 32'd1;
        if (wr_frames) frames_d = 32'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_ALIGN;
            aligned_q <= 1'b0;
            desync_q  <= 1'b0;
            ctrl_q    <= 2'b00;
            sh_en_q   <= 1'b0;
            sh_inv_q  <= 1'b0;
            frames_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            aligned_q <= aligned_d;
            desync_q  <= desync_d;
            ctrl_q    <= ctrl_d;
            sh_en_q   <= sh_en_d;
            sh_inv_q  <= sh_inv_d;
            frames_q  <= frames_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                key_q[k] <= '0;
                tol_q[k] <= '0;
            end
        end else if (avs_write) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (avs_address == 4'(4 + 2 * k)) key_q[k] <= avs_writedata[PW-1:0];
                if (avs_address == 4'(5 + 2 * k)) tol_q[k] <= avs_writedata[PW-1:0];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            for (int c = 0; c < 3; c++) begin
                diff_d[k][c] = abs_diff(fg_data[c*COLOR_BITS +: COLOR_BITS],
                                        key_q[k][c*COLOR_BITS +: COLOR_BITS]);
            end
        end
    end

    always_comb begin
        match_any = 1'b0;
        key_hit   = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            key_hit = 1'b1;
            for (int c = 0; c < 3; c++) begin
                if (s1_diff_q[k][c] > {1'b0, tol_q[k][c*COLOR_BITS +: COLOR_BITS]}) key_hit = 1'b0;
            end
            match_any = match_any | key_hit;
        end
        sel_bg    = s1_en_q & (match_any ^ s1_inv_q);
        s2_data_d = sel_bg ? s1_bg_q : s1_fg_q;
    end

    // Both stages move together; a dropped (desynced) pair simply leaves a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            s1_en_q    <= 1'b0;
            s1_inv_q   <= 1'b0;
            s1_fg_q    <= '0;
            s1_bg_q    <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                for (int c = 0; c < 3; c++) s1_diff_q[k][c] <= '0;
            end
            s2_valid_q <= 1'b0;
            s2_sop_q   <= 1'b0;
            s2_eop_q   <= 1'b0;
            s2_data_q  <= '0;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            s2_sop_q   <= s1_sop_q;
            s2_eop_q   <= s1_eop_q;
            s2_data_q  <= s2_data_d;
            s1_valid_q <= pair_ok;
            s1_sop_q   <= fg_sop;
            s1_eop_q   <= fg_eop;
            s1_en_q    <= en_eff;
            s1_inv_q   <= inv_eff;
            s1_fg_q    <= fg_data;
            s1_bg_q    <= bg_data;
            for (int k = 0; k < NUM_KEYS; k++) begin
                for (int c = 0; c < 3; c++) s1_diff_q[k][c] <= diff_d[k][c];
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sop   = s2_sop_q;
    assign out_eop   = s2_eop_q;
    assign out_data  = s2_data_q;

`ifdef CHROMA_KEY_MIXER_KEYED_COUNT_EN
    logic        s2_keyed_q;
    logic [31:0] kcnt_q, kcnt_d, ktot_q, ktot_d, kinc;

    always_comb begin
        kcnt_d = kcnt_q;
        ktot_d = ktot_q;
        kinc   = (s2_keyed_q && (kcnt_q != 32'hFFFF_FFFF)) ? kcnt_q + 32'd1 : kcnt_q;
        if (out_fire) begin
            if (s2_eop_q) begin
                ktot_d = kinc;
                kcnt_d = 32'd0;
            end else begin
                kcnt_d = kinc;
            end
        end
        if (avs_write && (avs_address == 4'd3)) begin
            kcnt_d = 32'd0;
            ktot_d = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_keyed_q <= 1'b0;
            kcnt_q     <= 32'd0;
            ktot_q     <= 32'd0;
        end else begin
            if (adv) s2_keyed_q <= s1_en_q & match_any;
            kcnt_q <= kcnt_d;
            ktot_q <= ktot_d;
        end
    end

    assign keyed_rd = ktot_q;
`else
    assign keyed_rd = 32'd0;
`endif

    always_comb begin
        rd_d = 32'd0;
        case (avs_address)
            4'd0:    rd_d = {30'd0, ctrl_q};
            4'd1:    rd_d = {30'd0, desync_q, aligned_q};
            4'd2:    rd_d = frames_q;
            4'd3:    rd_d = keyed_rd;
            default: begin
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if (avs_address == 4'(4 + 2 * k)) rd_d = 32'(key_q[k]);
                    if (avs_address == 4'(5 + 2 * k)) rd_d = 32'(tol_q[k]);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= 32'd0;
        end else if (avs_read) begin
            avs_readdata <= rd_d;
        end
    end

    assign unused_wdata = &{1'b0, avs_writedata[31:PW]};

endmodule

// File: tb/tb_chroma_key_mixer.sv
// tb/tb_chroma_key_mixer.sv - scoreboard bench for chroma_key_mixer with directed frames
module tb_chroma_key_mixer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] fg_data, bg_data, out_data;
    logic        fg_valid, fg_sop, fg_eop, fg_ready;
    logic        bg_valid, bg_sop, bg_eop, bg_ready;
    logic        out_valid, out_sop, out_eop, out_ready;
    logic [3:0]  avs_address;
    logic        avs_write, avs_read;
    logic [31:0] avs_writedata, avs_readdata;

    always #5 clk = ~clk;

    chroma_key_mixer #(.COLOR_BITS(8), .NUM_KEYS(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .fg_data(fg_data), .fg_valid(fg_valid), .fg_sop(fg_sop), .fg_eop(fg_eop), .fg_ready(fg_ready),
        .bg_data(bg_data), .bg_valid(bg_valid), .bg_sop(bg_sop), .bg_eop(bg_eop), .bg_ready(bg_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_ready(out_ready),
        .avs_address(avs_address), .avs_write(avs_write), .avs_read(avs_read),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int first_acc = 0;
    int first_out = 0;
    logic acc_arm = 1'b0;
    logic lat_arm = 1'b0;
    logic bp_mode = 1'b0;

    logic [25:0] fg_q[$];
    logic [25:0] bg_q[$];
    logic [25:0] exp_q[$];
    logic [23:0] fgt[32];
    logic [23:0] bgt[32];
    logic [23:0] ext[32];
    logic [31:0] rd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        @(posedge clk); #1;
        avs_write = 1'b0;
    endtask

    task automatic reg_rd(input logic [3:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read = 1'b1;
        @(posedge clk); #1;
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic queue_frame(input int n);
        for (int i = 0; i < n; i++) begin
            fg_q.push_back({i == 0, i == n - 1, fgt[i]});
            bg_q.push_back({i == 0, i == n - 1, bgt[i]});
            exp_q.push_back({i == 0, i == n - 1, ext[i]});
        end
    endtask

    task automatic run_streams(input int max_cyc);
        int n;
        logic ff, bf;
        logic [25:0] dump;
        n = 0;
        while ((fg_q.size() > 0 || bg_q.size() > 0) && n < max_cyc) begin
            if (fg_q.size() > 0) begin {fg_sop, fg_eop, fg_data} = fg_q[0]; fg_valid = 1'b1; end
            else fg_valid = 1'b0;
            if (bg_q.size() > 0) begin {bg_sop, bg_eop, bg_data} = bg_q[0]; bg_valid = 1'b1; end
            else bg_valid = 1'b0;
            @(negedge clk);
            ff = fg_valid && fg_ready;
            bf = bg_valid && bg_ready;
            if (ff && acc_arm) begin first_acc = cyc; acc_arm = 1'b0; end
            @(posedge clk); #1;
            if (ff) dump = fg_q.pop_front();
            if (bf) dump = bg_q.pop_front();
            n++;
        end
        fg_valid = 1'b0;
        bg_valid = 1'b0;
        if (fg_q.size() > 0 || bg_q.size() > 0) begin
            checks++; failures++;
            $display("FAIL stream_timeout: fg left %0d bg left %0d required 0", fg_q.size(), bg_q.size());
            fg_q.delete(); bg_q.delete();
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        check("drain_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        fg_valid = 1'b0; fg_sop = 1'b0; fg_eop = 1'b0; fg_data = '0;
        bg_valid = 1'b0; bg_sop = 1'b0; bg_eop = 1'b0; bg_data = '0;
        avs_write = 1'b0; avs_read = 1'b0; avs_address = '0; avs_writedata = '0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_fg_ready", {30'd0, fg_ready, bg_ready}, 32'd0);
        check("rst_out_data", {8'd0, out_data}, 32'd0);
        check("rst_readdata", avs_readdata, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin : monitor
        logic [25:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                if (lat_arm) begin first_out = cyc; lat_arm = 1'b0; end
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL out_unexpected: got 0x%0h with sop=%0b eop=%0b expected no beat",
                             out_data, out_sop, out_eop);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pixel", {6'd0, out_sop, out_eop, out_data}, {6'd0, e});
                end
            end
        end
    end

    initial begin : ready_driver
        int idx;
        logic [3:0] pat;
        pat = 4'b1001;
        idx = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_mode) begin
                out_ready = pat[idx] & ($urandom_range(0, 7) != 0);
                idx = (idx + 1) % 4;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        do_reset();
        reg_rd(4'd0, rd); check("rst_ctrl", rd, 32'd0);
        reg_rd(4'd1, rd); check("rst_status", rd, 32'd0);
        reg_rd(4'd2, rd); check("rst_frames", rd, 32'd0);

        // Basic keying, latency, frame counter
        reg_wr(4'd4, 32'h00FF00);
        reg_wr(4'd5, 32'h000000);
        reg_wr(4'd0, 32'h1);
        reg_rd(4'd4, rd); check("key0_readback", rd, 32'h00FF00);
        for (int i = 0; i < 4; i++) begin fgt[i] = 24'h00FF00; bgt[i] = 24'h123456; ext[i] = 24'h123456; end
        queue_frame(4);
        acc_arm = 1'b1; lat_arm = 1'b1;
        run_streams(100);
        wait_drain(50);
        check("latency", first_out - first_acc, 2);
        reg_rd(4'd2, rd); check("frames_1", rd, 32'd1);
        reg_rd(4'd1, rd); check("status_aligned", rd, 32'h1);

        // Tolerance boundary
        reg_wr(4'd5, 32'h040404);
        fgt[0] = 24'h04FB04; bgt[0] = 24'hAAAAAA; ext[0] = 24'hAAAAAA;
        fgt[1] = 24'h05FF00; bgt[1] = 24'hBBBBBB; ext[1] = 24'h05FF00;
        queue_frame(2);
        run_streams(100);
        wait_drain(50);

        // Invert written mid-frame applies only from the next frame
        for (int i = 0; i < 6; i++) begin
            fgt[i] = 24'h00FF00; bgt[i] = 24'h300000 + 24'(i); ext[i] = 24'h300000 + 24'(i);
        end
        queue_frame(6);
        fork
            run_streams(100);
            begin repeat (3) @(posedge clk); #1; reg_wr(4'd0, 32'h3); end
        join
        for (int i = 0; i < 6; i++) ext[i] = 24'h00FF00;
        queue_frame(6);
        run_streams(100);
        wait_drain(50);
        reg_rd(4'd2, rd); check("frames_4", rd, 32'd4);
        reg_wr(4'd0, 32'h1);

        // Background starts mid-frame after reset
        do_reset();
        reg_wr(4'd4, 32'h00FF00);
        reg_wr(4'd0, 32'h1);
        for (int i = 0; i < 3; i++) bg_q.push_back({2'b00, 24'h999990 + 24'(i)});
        fgt[0] = 24'h00FF00; bgt[0] = 24'hB0B0B0; ext[0] = 24'hB0B0B0;
        fgt[1] = 24'h101010; bgt[1] = 24'hB1B1B1; ext[1] = 24'h101010;
        fgt[2] = 24'h00FF00; bgt[2] = 24'hB2B2B2; ext[2] = 24'hB2B2B2;
        fgt[3] = 24'h202020; bgt[3] = 24'hB3B3B3; ext[3] = 24'h202020;
        queue_frame(4);
        run_streams(100);
        wait_drain(50);
        reg_rd(4'd1, rd); check("status_realigned", rd, 32'h1);
        reg_rd(4'd2, rd); check("frames_after_rst", rd, 32'd1);

        // fg_eop one beat early: desync and recovery
        fg_q.push_back({2'b10, 24'h00FF00}); bg_q.push_back({2'b10, 24'hD0D0D0});
        fg_q.push_back({2'b00, 24'hC1C1C1}); bg_q.push_back({2'b00, 24'hD1D1D1});
        fg_q.push_back({2'b01, 24'hC2C2C2}); bg_q.push_back({2'b00, 24'hD2D2D2});
        bg_q.push_back({2'b01, 24'hD3D3D3});
        exp_q.push_back({2'b10, 24'hD0D0D0});
        exp_q.push_back({2'b00, 24'hC1C1C1});
        run_streams(100);
        wait_drain(50);
        reg_rd(4'd1, rd); check("status_desync", rd, 32'h2);
        fgt[0] = 24'h00FF00; bgt[0] = 24'hF0F0F0; ext[0] = 24'hF0F0F0;
        fgt[1] = 24'hE1E1E1; bgt[1] = 24'hF1F1F1; ext[1] = 24'hE1E1E1;
        fgt[2] = 24'h00FF00; bgt[2] = 24'hF2F2F2; ext[2] = 24'hF2F2F2;
        fgt[3] = 24'hE3E3E3; bgt[3] = 24'hF3F3F3; ext[3] = 24'hE3E3E3;
        queue_frame(4);
        run_streams(100);
        wait_drain(50);
        reg_rd(4'd1, rd); check("status_recovered", rd, 32'h3);
        reg_wr(4'd1, 32'h2);
        reg_rd(4'd1, rd); check("status_cleared", rd, 32'h1);
        reg_rd(4'd2, rd); check("frames_2", rd, 32'd2);
        reg_wr(4'd2, 32'h5);
        reg_rd(4'd2, rd); check("frames_clear", rd, 32'd0);
        reg_wr(4'd8, 32'hFFFFFF);
        reg_rd(4'd8, rd); check("key2_absent", rd, 32'd0);

        // Backpressure over a 16-pixel frame
        for (int i = 0; i < 16; i++) begin
            fgt[i] = (i % 2 == 0) ? 24'h00FF00 : 24'h010101 * 24'(i);
            bgt[i] = 24'h800000 + 24'(i);
            ext[i] = (i % 2 == 0) ? bgt[i] : fgt[i];
        end
        queue_frame(16);
        bp_mode = 1'b1;
        run_streams(400);
        wait_drain(400);
        bp_mode = 1'b0;
        reg_rd(4'd2, rd); check("frames_bp", rd, 32'd1);

        // Keyed count via KEY_1
        reg_wr(4'd4, 32'h123123);
        reg_wr(4'd6, 32'h0A0B0C);
        reg_wr(4'd7, 32'h010101);
        fgt[0] = 24'h0A0B0C; fgt[1] = 24'h0B0C0D; fgt[2] = 24'h0C0B0C; fgt[3] = 24'h090A0B;
        fgt[4] = 24'h0A0D0C; fgt[5] = 24'h0A0B0D; fgt[6] = 24'h0B0A0C; fgt[7] = 24'h000000;
        for (int i = 0; i < 8; i++) bgt[i] = 24'h770000 + 24'(i);
        ext[0] = bgt[0]; ext[1] = bgt[1]; ext[2] = fgt[2]; ext[3] = bgt[3];
        ext[4] = fgt[4]; ext[5] = bgt[5]; ext[6] = bgt[6]; ext[7] = fgt[7];
        queue_frame(8);
        run_streams(100);
        wait_drain(50);
        reg_rd(4'd3, rd);
`ifdef CHROMA_KEY_MIXER_KEYED_COUNT_EN
        check("keyed_count", rd, 32'd5);
`else
        check("keyed_count", rd, 32'd0);
`endif
        reg_wr(4'd3, 32'h0);
        reg_rd(4'd3, rd); check("keyed_clear", rd, 32'd0);
        reg_rd(4'd2, rd); check("frames_final", rd, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
